// File: rtl/uart_alu_ctrl_pkg.sv
// Shared state encoding and default widths for the UART <-> ALU sequencer.
package uart_alu_ctrl_pkg;

  localparam int NB_DATA_DEFAULT = 8;
  localparam int NB_OP_DEFAULT   = 6;

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    GET_B   = 3'd1,
    GET_OP  = 3'd2,
    LOAD    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

endpackage

// File: rtl/uart_alu_ctrl_timer.sv
// Inter-byte timeout counter: clear has priority, counts while enabled and
// flags expiry on its last count, then wraps to zero.
module uart_alu_ctrl_timer #(
  parameter int TIMEOUT_CYCLES = 1000000
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // A byte arriving in the expiry cycle must win, so clear masks the flag.
  assign o_expire = i_enable & ~i_clear & (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B, opcode from the UART Rx, feeds the ALU and hands the result
// to the UART Tx. Optional inter-byte timeout: define UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int NB_OP          = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYCLES = 1000000
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_drop,
  output logic               o_timeout
);

  state_e             state_q, state_d;
  logic               rx_done_q;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, tx_data_q, tx_data_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic               tx_start_q, tx_start_d, drop_q, drop_d, timeout_q, timeout_d;
  logic               rx_ev, tmr_expire;

  // Rx may hold done high for a whole baud tick; only its rising edge counts.
  assign rx_ev = i_rx_done & ~rx_done_q;

`ifdef UART_ALU_CTRL_TIMEOUT_EN
  logic tmr_en;
  assign tmr_en = (state_q == GET_B) || (state_q == GET_OP);

  uart_alu_ctrl_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (rx_ev),
    .i_enable (tmr_en),
    .o_expire (tmr_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmr_expire         = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    drop_d     = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      GET_A: begin
        if (rx_ev) begin
          alu_a_d = i_rx_data;
          state_d = GET_B;
        end
      end
      GET_B: begin
        if (rx_ev) begin
          alu_b_d = i_rx_data;
          state_d = GET_OP;
        end else if (tmr_expire) begin
          timeout_d = 1'b1;
          state_d   = GET_A;
        end
      end
      GET_OP: begin
        if (rx_ev) begin
          alu_op_d = i_rx_data[NB_OP-1:0];
          state_d  = LOAD;
        end else if (tmr_expire) begin
          timeout_d = 1'b1;
          state_d   = GET_A;
        end
      end
      LOAD: begin
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        drop_d     = rx_ev;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte coinciding with tx_done opens the next frame instead of dropping.
        if (i_tx_done && rx_ev) begin
          alu_a_d = i_rx_data;
          state_d = GET_B;
        end else if (i_tx_done) begin
          state_d = GET_A;
        end else begin
          drop_d = rx_ev;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= GET_A;
      rx_done_q  <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_done_q  <= i_rx_done;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q == LOAD) || (state_q == WAIT_TX);
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;

endmodule
